traffic_phase_controller: RTL
=============================

Name: traffic_phase_controller

Overview:
- Master sequencer for one two-way intersection (north-south / east-west).
- Runs the vehicle signal phase state machine and generates the 7-bit master_timer countdown.
- Latches pedestrian push-button requests and produces the per-direction pedestrian enables.
- Directly feeds the pedestrian light stage, one instance per direction, via master_timer and ns_ped_enable / ew_ped_enable.

Parameters:
- TICK_DIV, 50000000, clock cycles per 1-second tick; legal range 1..2^26.
- GREEN_TIME, 60, green phase length in seconds; legal range 1..127.
- YELLOW_TIME, 4, yellow phase length in seconds; legal range 1..127.
- RED_TIME, 2, all-red clearance length in seconds; legal range 1..127.
- WALK_END, 30, walk enable is held while master_timer > WALK_END; legal range 0..GREEN_TIME-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ns_ped_req  input  1  north-south crossing button; level or pulse, sampled each clk.
- ew_ped_req  input  1  east-west crossing button; level or pulse, sampled each clk.
- master_timer  output  7  seconds remaining in the current phase.
- phase  output  3  current state encoding.
- ns_ped_enable  output  1  walk enable for the north-south pedestrian light.
- ew_ped_enable  output  1  walk enable for the east-west pedestrian light.
- ns_red, ns_yellow, ns_green  output  1 each  north-south vehicle lamps, one-hot.
- ew_red, ew_yellow, ew_green  output  1 each  east-west vehicle lamps, one-hot.

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - phase = RED_NS (0), master_timer = RED_TIME, prescaler = 0.
  - Both pending and both active request flags = 0.
  - ns_red = ew_red = 1; all other lamps = 0; both ped enables = 0.
  - Reset asserted mid-phase aborts that phase immediately; nothing is retained.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is a one-clk internal strobe asserted when the count = TICK_DIV-1.
  - TICK_DIV = 1 gives tick on every clk.
- States and encodings: RED_NS = 0, NS_GREEN = 1, NS_YELLOW = 2, RED_EW = 3, EW_GREEN = 4, EW_YELLOW = 5.
- Codes 6 and 7 are illegal; if reached, the next clk goes to RED_NS with master_timer = RED_TIME.
- Sequence: 0 -> 1 -> 2 -> 3 -> 4 -> 5 -> 0.
- Phase durations: RED_TIME for states 0 and 3, GREEN_TIME for 1 and 4, YELLOW_TIME for 2 and 5.
- Timer:
  - On tick with master_timer > 1: master_timer decrements by 1.
  - On tick with master_timer == 1: phase advances and master_timer loads the new phase's duration in the same clk.
  - master_timer therefore shows D..1 and never 0. A phase of duration D lasts exactly D ticks.
  - No change without tick.
- Lamps are a registered decode of the phase:
  - ns_green in state 1, ns_yellow in state 2, ns_red otherwise.
  - ew_green in state 4, ew_yellow in state 5, ew_red otherwise.
  - Exactly one lamp per direction is high at any time.
- Requests:
  - ns_ped_req high sets ns_pending. Same for ew.
  - On the clk that enters NS_GREEN: ns_active <= ns_pending OR ns_ped_req, and ns_pending clears.
  - A request arriving in that same clk is therefore served, not lost.
  - A request raised during NS_GREEN sets pending and is served at the next NS_GREEN.
  - ns_active clears on leaving NS_GREEN. The EW flags mirror this around EW_GREEN.
- Pedestrian enables:
  - ns_ped_enable = ns_active AND phase == NS_GREEN AND master_timer > WALK_END.
  - ew_ped_enable uses the EW equivalents.
  - Both are combinational from registers, so they are valid in the same clk as master_timer.
  - They drop in the clk where master_timer becomes WALK_END, which is when the downstream countdown display appears.
  - They are never both high.
- master_timer is only meaningful downstream for the direction whose enable is active. Downstream blanks values above 30.

Test Plan (TICK_DIV = 1, GREEN_TIME = 60, YELLOW_TIME = 4, RED_TIME = 2, WALK_END = 30 unless stated):
- Assert reset -> phase = 0, master_timer = 2, ns_red = ew_red = 1, all greens/yellows = 0, both ped enables = 0.
- Release reset, no requests -> after 2 ticks phase = 1, master_timer = 60, ns_green = 1; ns_ped_enable stays 0; yellow at tick 62, phase 3 at tick 66; full cycle returns to phase 0 after 132 ticks.
- Pulse ns_ped_req for 1 clk during RED_NS -> ns_ped_enable = 1 for master_timer 60..31, then 0 at master_timer = 30; ew_ped_enable stays 0.
- Pulse ew_ped_req during EW_GREEN at master_timer = 50 -> no enable in that green; at the next EW_GREEN, ew_ped_enable = 1 from 60 down to 31.
- Assert ns_ped_req exactly on the clk entering NS_GREEN -> served in that green (enable = 1 at master_timer = 60); pending = 0 afterwards.
- TICK_DIV = 4: master_timer changes every 4 clks. Assert reset mid EW_GREEN at master_timer = 45 with ew_active = 1 -> same cycle: phase = 0, master_timer = 2, ew_ped_enable = 0, prescaler = 0.

Source files
------------

// File: rtl/traffic_phase_controller.sv
// Master phase sequencer for a two-way intersection.
// Runs the vehicle phase FSM with a 1-second prescaler and the master_timer
// countdown. It also latches pedestrian requests and produces the
// per-direction walk enables that feed the downstream pedestrian lights.
module traffic_phase_controller #(
    parameter int TICK_DIV    = 50000000,
    parameter int GREEN_TIME  = 60,
    parameter int YELLOW_TIME = 4,
    parameter int RED_TIME    = 2,
    parameter int WALK_END    = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ns_ped_req,
    input  logic       ew_ped_req,
    output logic [6:0] master_timer,
    output logic [2:0] phase,
    output logic       ns_ped_enable,
    output logic       ew_ped_enable,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green
);

    localparam logic [2:0] RED_NS    = 3'd0;
    localparam logic [2:0] NS_GREEN  = 3'd1;
    localparam logic [2:0] NS_YELLOW = 3'd2;
    localparam logic [2:0] RED_EW    = 3'd3;
    localparam logic [2:0] EW_GREEN  = 3'd4;
    localparam logic [2:0] EW_YELLOW = 3'd5;

    // A one-entry counter still needs one bit, so TICK_DIV = 1 gets PW = 1.
    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]     RED_LEN   = 7'(RED_TIME);
    localparam logic [6:0]     GREEN_LEN = 7'(GREEN_TIME);
    localparam logic [6:0]     YEL_LEN   = 7'(YELLOW_TIME);
    localparam logic [6:0]     WALK_LIM  = 7'(WALK_END);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic [2:0]    phase_q, phase_d;
    logic [6:0]    timer_q, timer_d;
    logic          ns_pending_q, ns_pending_d, ew_pending_q, ew_pending_d;
    logic          ns_active_q, ns_active_d, ew_active_q, ew_active_d;
    // Lamp bits: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
    logic [5:0]    lamps_q, lamps_d;
    logic          ns_enter, ew_enter;

    // Duration loaded into master_timer when a phase is entered.
    function automatic logic [6:0] phase_len(input logic [2:0] p);
        case (p)
            NS_GREEN, EW_GREEN:   phase_len = GREEN_LEN;
            NS_YELLOW, EW_YELLOW: phase_len = YEL_LEN;
            default:              phase_len = RED_LEN;
        endcase
    endfunction

    // Prescaler: one-clk tick when the count reaches TICK_DIV-1, then wrap.
    always_comb begin
        tick    = (presc_q == TICK_LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Phase/timer sequencing: count down on tick and advance at 1, so the
    // timer shows D..1 and a phase lasts exactly D ticks.
    always_comb begin
        phase_d = phase_q;
        timer_d = timer_q;
        if (phase_q > EW_YELLOW) begin
            phase_d = RED_NS;
            timer_d = RED_LEN;
        end else if (tick) begin
            if (timer_q > 7'd1) begin
                timer_d = timer_q - 7'd1;
            end else begin
                phase_d = (phase_q == EW_YELLOW) ? RED_NS : phase_q + 3'd1;
                timer_d = phase_len(phase_d);
            end
        end
    end

    // Request latching: a request that arrives on the green-entry clk is
    // folded into active directly, so it is served rather than lost.
    always_comb begin
        ns_enter     = (phase_d == NS_GREEN) && (phase_q != NS_GREEN);
        ew_enter     = (phase_d == EW_GREEN) && (phase_q != EW_GREEN);
        ns_pending_d = ns_enter ? 1'b0 : (ns_pending_q | ns_ped_req);
        ew_pending_d = ew_enter ? 1'b0 : (ew_pending_q | ew_ped_req);
        ns_active_d  = ns_enter ? (ns_pending_q | ns_ped_req)
                                : ((phase_d == NS_GREEN) && ns_active_q);
        ew_active_d  = ew_enter ? (ew_pending_q | ew_ped_req)
                                : ((phase_d == EW_GREEN) && ew_active_q);
    end

    // Lamp decode from the next phase so the registered lamps line up with phase.
    always_comb begin
        lamps_d = 6'b100_100;
        case (phase_d)
            NS_GREEN:  lamps_d = 6'b001_100;
            NS_YELLOW: lamps_d = 6'b010_100;
            EW_GREEN:  lamps_d = 6'b100_001;
            EW_YELLOW: lamps_d = 6'b100_010;
            default:   lamps_d = 6'b100_100;
        endcase
    end

    // State registers; reset aborts any phase in progress immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            phase_q      <= RED_NS;
            timer_q      <= RED_LEN;
            ns_pending_q <= 1'b0;
            ew_pending_q <= 1'b0;
            ns_active_q  <= 1'b0;
            ew_active_q  <= 1'b0;
            lamps_q      <= 6'b100_100;
        end else begin
            presc_q      <= presc_d;
            phase_q      <= phase_d;
            timer_q      <= timer_d;
            ns_pending_q <= ns_pending_d;
            ew_pending_q <= ew_pending_d;
            ns_active_q  <= ns_active_d;
            ew_active_q  <= ew_active_d;
            lamps_q      <= lamps_d;
        end
    end

    assign master_timer  = timer_q;
    assign phase         = phase_q;
    // Walk drops in the clk where the timer reaches WALK_END, the point at
    // which the downstream countdown display takes over.
    assign ns_ped_enable = ns_active_q && (phase_q == NS_GREEN) && (timer_q > WALK_LIM);
    assign ew_ped_enable = ew_active_q && (phase_q == EW_GREEN) && (timer_q > WALK_LIM);
    assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = lamps_q;

endmodule
